// File: rtl/pipelined_add_sub.sv
// Pipelined ripple adder/subtractor.
// The N-bit operation is split into S slices of N/S bits. Stage k adds slice k
// using the carry registered by stage k-1. Each stage register carries the full
// operand and partial-sum vectors, so a transaction's slices always move
// together. The last stage register drives the outputs directly. The whole
// pipe stalls as one unit under output back-pressure.

module pipelined_add_sub_stage #(
    parameter int N = 16,
    parameter int W = 4,
    parameter int K = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         vld_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [N-1:0] sum_i,
    input  logic         c_i,
    output logic         vld_o,
    output logic [N-1:0] a_o,
    output logic [N-1:0] b_o,
    output logic [N-1:0] sum_o,
    output logic         c_o,
    output logic         ovf_o
);

    logic [W:0]   slice;
    logic [N-1:0] sum_nx;
    logic         ovf_nx;

    // Add this stage's slice.
    // The overflow term only means something in the stage that writes the MSB.
    always_comb begin
        slice  = {1'b0, a_i[K*W +: W]} + {1'b0, b_i[K*W +: W]} + {{W{1'b0}}, c_i};
        sum_nx = sum_i;
        sum_nx[K*W +: W] = slice[W-1:0];
        ovf_nx = (a_i[N-1] == b_i[N-1]) && (sum_nx[N-1] != a_i[N-1]);
    end

    // The valid bit follows the pipe on every advance, including bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_o <= 1'b0;
        else if (en)
            vld_o <= vld_i;
    end

    // Data loads only when a real transaction moves in.
    // Bubbles leave the previous contents untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_o   <= '0;
            b_o   <= '0;
            sum_o <= '0;
            c_o   <= 1'b0;
            ovf_o <= 1'b0;
        end else if (en && vld_i) begin
            a_o   <= a_i;
            b_o   <= b_i;
            sum_o <= sum_nx;
            c_o   <= slice[W];
            ovf_o <= ovf_nx;
        end
    end

endmodule

module pipelined_add_sub #(
    parameter int N = 16,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   total,
    output logic         ovf
);

    localparam int W = N / S;

    if (N % S != 0) begin : g_bad_split
        $error("pipelined_add_sub: N must be a multiple of S");
    end

    // Index 0 is the input side; index k+1 is the register of stage k.
    logic [S:0]          vld_pipe;
    logic [S:0][N-1:0]   a_p;
    logic [S:0][N-1:0]   b_p;
    logic [S:0][N-1:0]   sum_p;
    logic [S:0]          c_p;
    logic [S-1:0]        ovf_p;
    logic                adv;

    // A stalled result blocks every stage. Otherwise the whole pipe shifts.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtract is done as A + ~B + ~cin.
    // That way carry-out = 1 means "no borrow".
    assign vld_pipe[0] = in_valid;
    assign a_p[0]      = A;
    assign b_p[0]      = sub ? ~B : B;
    assign sum_p[0]    = '0;
    assign c_p[0]      = sub ? ~cin : cin;

    for (genvar k = 0; k < S; k++) begin : g_stage
        pipelined_add_sub_stage #(
            .N (N),
            .W (W),
            .K (k)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .vld_i (vld_pipe[k]),
            .a_i   (a_p[k]),
            .b_i   (b_p[k]),
            .sum_i (sum_p[k]),
            .c_i   (c_p[k]),
            .vld_o (vld_pipe[k+1]),
            .a_o   (a_p[k+1]),
            .b_o   (b_p[k+1]),
            .sum_o (sum_p[k+1]),
            .c_o   (c_p[k+1]),
            .ovf_o (ovf_p[k])
        );
    end

    assign out_valid = vld_pipe[S];
    assign total     = {c_p[S], sum_p[S]};
    assign ovf       = ovf_p[S-1];

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed and random checks for pipelined_add_sub at N=16, S=4.
module tb_pipelined_add_sub;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] total;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    // Hand-computed vectors: A, B, cin, sub -> total, ovf.
    logic [15:0] ta [0:7] = '{16'h0001, 16'h1234, 16'h8000, 16'hFFFF,
                              16'h0010, 16'h8000, 16'h0000, 16'h00FF};
    logic [15:0] tb_ [0:7] = '{16'h0002, 16'h4321, 16'h8000, 16'hFFFF,
                               16'h0001, 16'h0001, 16'h0000, 16'h0F01};
    logic        tc [0:7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        ts [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [16:0] te [0:7] = '{17'h00003, 17'h05556, 17'h10000, 17'h1FFFF,
                              17'h1000F, 17'h17FFF, 17'h0FFFF, 17'h01000};
    logic        to [0:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    pipelined_add_sub #(.N(16), .S(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .total     (total),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s);
        A = a; B = b; cin = c; sub = s; in_valid = 1'b1;
    endtask

    task automatic drive_idx(input int i);
        drive(ta[i], tb_[i], tc[i], ts[i]);
    endtask

    function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic c, input logic s);
        logic [15:0] be;
        logic        ce;
        logic [16:0] t;
        logic        o;
        be = s ? ~b : b;
        ce = s ? ~c : c;
        t  = {1'b0, a} + {1'b0, be} + {16'b0, ce};
        o  = (a[15] == be[15]) && (t[15] != a[15]);
        return {o, t};
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (total !== 17'h0) begin errors++; $display("FAIL reset_total: got %h want 00000", total); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        step(); step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_carry_out();
        // Input is presented in the same cycle reset is released.
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        step(); step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got %b want 0 at cycle 3", out_valid); end
        step();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b want 1 at cycle 4", out_valid); end
        checks++;
        if (total !== 17'h10000) begin errors++; $display("FAIL carry_total: got %h want 10000", total); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL carry_ovf: got %b want 0", ovf); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL carry_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_overflow_sub();
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        step();
        drive(16'h0005, 16'h0007, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        step(); step();
        checks++;
        if (total !== 17'h08000 || ovf !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL ovf_add: got v=%b %h o=%b want v=1 08000 o=1", out_valid, total, ovf);
        end
        step();
        checks++;
        if (total !== 17'h0FFFE || ovf !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL sub_borrow: got v=%b %h o=%b want v=1 0FFFE o=0", out_valid, total, ovf);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive_idx(0);
        for (int c = 1; c <= 12; c++) begin
            step();
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1 cycle %0d", in_ready, c); end
            if (c >= 4 && c < 12) begin
                checks++;
                if (out_valid !== 1'b1 || total !== te[c-4] || ovf !== to[c-4]) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got v=%b %h o=%b want v=1 %h o=%b",
                             c-4, out_valid, total, ovf, te[c-4], to[c-4]);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0 cycle %0d", out_valid, c); end
            end
            if (c < 8) drive_idx(c);
            else in_valid = 1'b0;
        end
    endtask

    task automatic test_stall();
        int got;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive_idx(c);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
            checks++;
            if (out_valid !== 1'b1 || total !== te[0]) begin
                errors++; $display("FAIL stall_hold: got v=%b %h want v=1 %h", out_valid, total, te[0]);
            end
            step();
        end
        out_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (got >= 4) begin
                    errors++; $display("FAIL stall_extra: got %h want no more results", total);
                end else if (total !== te[got]) begin
                    errors++; $display("FAIL stall_order%0d: got %h want %h", got, total, te[got]);
                end
                got++;
            end
            step();
        end
        checks++;
        if (got != 4) begin errors++; $display("FAIL stall_count: got %0d want 4", got); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive_idx(c);
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || total !== te[1]) begin
            errors++; $display("FAIL pre_reset: got v=%b %h want v=1 %h", out_valid, total, te[1]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || total !== 17'h0 || ovf !== 1'b0) begin
            errors++; $display("FAIL async_reset: got v=%b %h o=%b want v=0 00000 o=0", out_valid, total, ovf);
        end
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_result: got v=%b %h want v=0", out_valid, total); end
        end
    endtask

    task automatic test_random();
        logic [17:0] q[$];
        logic [17:0] exp_v;
        for (int i = 0; i < 10020; i++) begin
            if (i < 10000) begin
                A = 16'($urandom); B = 16'($urandom);
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected: got %h want no result", total);
                end else begin
                    exp_v = q.pop_front();
                    if ({ovf, total} !== exp_v) begin
                        errors++; $display("FAIL rand_result: got o=%b %h want o=%b %h",
                                           ovf, total, exp_v[17], exp_v[16:0]);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(ref_model(A, B, cin, sub));
            step();
        end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL rand_lost: got %0d pending want 0", q.size()); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_carry_out();
        test_overflow_sub();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_add_sub.md
PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 SHALL have parameter N, default 16, meaning operand width in bits.
REQ-002 SHALL have parameter S, default 4, meaning pipeline stages; N mod S = 0; each stage adds one N/S-bit slice.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operand set present.
REQ-006 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-007 SHALL have port A, input, N, first operand.
REQ-008 SHALL have port B, input, N, second operand.
REQ-009 SHALL have port cin, input, 1, carry-in (add) or borrow-in (subtract).
REQ-010 SHALL have port sub, input, 1, 0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-013 SHALL have port total, output, N+1, {carry-out, N-bit sum}.
REQ-014 SHALL have port ovf, output, 1, two's-complement signed overflow.

Function
REQ-015 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-016 SHALL compute, for sub=0: total = A + B + cin, width N+1, no truncation.
REQ-017 SHALL compute, for sub=1: total = A + ~B + ~cin, so total[N-1:0] = A - B - cin and total[N] = 1 means no borrow.
REQ-018 SHALL set ovf = 1 when both effective operands (A, B or ~B) share a sign bit that differs from total[N-1].
REQ-019 SHALL process slice k (bits k*N/S .. (k+1)*N/S-1) in stage k, using the carry registered from stage k-1; stage 0 uses the effective carry-in.
REQ-020 SHALL delay the unprocessed upper operand slices and the completed lower sum slices with the transaction, so the slices of one result never mix with another.
REQ-021 SHALL have a latency of exactly S cycles from an accepted input to out_valid for that result, when there is no stall.
REQ-022 SHALL sustain one transfer per cycle while out_ready stays 1.
REQ-023 SHALL drive in_ready = !out_valid || out_ready (combinational); all stages advance together only when in_ready = 1.
REQ-024 SHALL freeze every stage, plus total, ovf and out_valid, while out_valid = 1 and out_ready = 0.
REQ-025 SHALL hold the data registers and stall behaviour unchanged while no transaction is present; only the per-stage valid bits clear.
REQ-026 SHALL, on a simultaneous output transfer and input acceptance, advance the pipeline with no bubble and no loss.
REQ-027 SHALL ignore A, B, cin and sub when the input is not transferred.
REQ-028 SHALL produce the exact ripple-carry result for S = 1 and S = N, with the behaviour otherwise identical.

Reset
REQ-029 SHALL, on rst_n = 0, immediately clear all stage valid bits and out_valid regardless of clk; in-flight transactions are discarded.
REQ-030 SHALL drive total = 0 and ovf = 0 while reset is asserted and after it.
REQ-031 SHALL first accept input on the first rising clk edge after rst_n deasserts.

Verification (N=16, S=4)
REQ-032 SHALL cover: A=0xFFFF, B=0x0001, cin=0, sub=0 -> after 4 cycles, out_valid=1, total=0x10000, ovf=0.
REQ-033 SHALL cover: A=0x7FFF, B=0x0001, sub=0 -> total=0x08000, ovf=1; then A=0x0005, B=0x0007, cin=0, sub=1 -> total=0x0FFFE, ovf=0.
REQ-034 SHALL cover: 8 back-to-back inputs with out_ready=1 -> 8 results on 8 consecutive cycles starting at cycle 4, in order, with in_ready held at 1.
REQ-035 SHALL cover: out_ready=0 for 5 cycles with a full pipe -> in_ready=0, total held stable; then out_ready=1 -> all results delivered in order, none lost or duplicated.
REQ-036 SHALL cover: rst_n pulsed low mid-clock with 3 results in flight -> out_valid=0 and total=0 immediately; no stale result after release.
REQ-037 SHALL cover: 10k random A, B, cin, sub and out_ready values -> every result matches a 17-bit reference model.
